m_cycle_cpu: RTL and testbench
==============================

M_CYCLE_CPU -- requirements
Module: m_cycle_cpu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL set the fetch address after reset.
REQ-002 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum wait cycles per memory transaction; 0 disables the timeout.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port mem_req, output, 1: memory transaction request.
REQ-006 Port mem_we, output, 1: write enable, 1 = store, 0 = fetch or load.
REQ-007 Port mem_addr, output, 32: byte address, word-aligned.
REQ-008 Port mem_wdata, output, 32: store data.
REQ-009 Port mem_rdata, input, 32: read data, valid in the cycle mem_ready=1.
REQ-010 Port mem_ready, input, 1: transaction completes on a rising edge where mem_req=1 and mem_ready=1.
REQ-011 Port halt, output, 1: core stopped on an illegal instruction, misaligned access or timeout.
REQ-012 Port pc_out, output, 32: current PC.
REQ-013 Port retired, output, 32: count of retired instructions.

Function
REQ-014 The core SHALL be a multi-cycle MIPS core with one unified memory port and states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 The supported instructions SHALL be addu, subu, and, or, slt, addiu, ori, lui, lw, sw, beq, bne, j, jal and jr; any other opcode or funct SHALL go DECODE->HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on completion IR<=mem_rdata, PC<=PC+4, ->DECODE.
REQ-017 DECODE: read rs and rt into the A and B latches; sign-extend imm (addiu, lw, sw, beq, bne); zero-extend imm (ori); ->EXEC.
REQ-018 EXEC, ALU ops: ALUOut<=result; slt is a signed compare; lui gives imm<<16; ->WB.
REQ-019 EXEC, lw/sw: ALUOut<=A+sext(imm); ALUOut[1:0]!=0 ->HALT; otherwise ->MEM.
REQ-020 EXEC, beq/bne: if taken, PC<=PC+(sext(imm)<<2), where PC is already PC+4; ->FETCH.
REQ-021 EXEC, j/jal: PC<={PC[31:28],IR[25:0],2'b00}; jal also writes $31<=PC(+4); ->FETCH.
REQ-022 EXEC, jr: PC<=A; A[1:0]!=0 ->HALT; ->FETCH.
REQ-023 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for sw with mem_wdata=B; on completion sw ->FETCH and lw latches MDR<=mem_rdata ->WB.
REQ-024 WB: write rd for R-type, rt for I-type ALU ops, or rt<=MDR for lw; ->FETCH.
REQ-025 Cycle counts with zero-wait memory SHALL be: lw 5; R-type, I-type ALU and sw 4; beq, bne, j, jal and jr 3. Each memory wait cycle adds 1.
REQ-026 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0; mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.
REQ-027 Each memory transaction SHALL count wait cycles; when the count reaches MEM_TIMEOUT with mem_ready still 0, the core SHALL go ->HALT.
REQ-028 Register $0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-029 Register read data SHALL reflect all writes from earlier instructions; there is no forwarding, because there is no overlap.
REQ-030 retired SHALL increment by 1 in the last cycle of each instruction and wrap from 32'hFFFF_FFFF to 0; instructions that halt SHALL not count.
REQ-031 In HALT, halt=1 and all state SHALL hold until reset; mem_ready received in HALT SHALL be ignored.

Reset
REQ-032 While reset=1: PC=RESET_PC, state=FETCH, all 32 registers=0, retired=0, halt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately; after reset deasserts, the first cycle SHALL assert mem_req with mem_addr=RESET_PC.

Verification
REQ-034 Scenario: zero-wait memory, ori $1,$0,0x1234 then addu $2,$1,$1 -> $2=0x2468 at cycle 8, retired=2.
REQ-035 Scenario: sw $2,4($0) then lw $3,4($0) with 3 wait cycles per access -> store at 0x4 with data 0x2468, $3=0x2468, lw takes 8 cycles.
REQ-036 Scenario: beq $0,$0,-1 at 0x3000 -> PC loops at 0x3000, 3 cycles per iteration, retired increments each time.
REQ-037 Scenario: jal 0x0C00 from 0x3004 -> $31=0x3008 and PC=0x3000; then jr $31 -> PC=0x3008.
REQ-038 Scenario: illegal opcode 6'h3F, or lw from address 0x2 -> halt=1, mem_req=0, retired unchanged; reset -> fetch at 0x3000.
REQ-039 Scenario: mem_ready held 0 for 16 cycles -> halt=1; preset retired=32'hFFFF_FFFF and retire one instruction -> retired=0.

Source files
------------

// File: rtl/m_cycle_cpu.sv
// Multi-cycle MIPS subset core with a single unified memory port.
// One instruction at a time: FETCH, DECODE, EXEC, optional MEM, optional WB.
module m_cycle_cpu #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halt,
    output logic [31:0] pc_out,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [31:0] WAIT_LAST = 32'(MEM_TIMEOUT) - 32'd1;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] imm_q;
    logic [31:0] alu_q;
    logic [31:0] mdr_q;
    logic [31:0] retired_q;
    logic [31:0] wait_q;
    logic [31:0] rf_q [32];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    logic is_r, is_addu, is_subu, is_and, is_or, is_slt, is_jr;
    logic is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic is_ralu, is_ialu, legal;
    logic branch_taken, mem_timeout;

    logic [31:0] alu_d;
    logic [31:0] br_target_d;
    logic [31:0] j_target_d;
    logic [31:0] wb_data_d;
    logic [4:0]  wb_idx_d;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign imm16 = ir_q[15:0];

    assign is_r     = (op == OP_RTYPE);
    assign is_addu  = is_r && (funct == FN_ADDU);
    assign is_subu  = is_r && (funct == FN_SUBU);
    assign is_and   = is_r && (funct == FN_AND);
    assign is_or    = is_r && (funct == FN_OR);
    assign is_slt   = is_r && (funct == FN_SLT);
    assign is_jr    = is_r && (funct == FN_JR);
    assign is_addiu = (op == OP_ADDIU);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_bne   = (op == OP_BNE);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);

    assign is_ralu = is_addu || is_subu || is_and || is_or || is_slt;
    assign is_ialu = is_addiu || is_ori || is_lui;
    assign legal   = is_ralu || is_ialu || is_lw || is_sw || is_beq || is_bne
                  || is_j || is_jal || is_jr;

    always_comb begin
        alu_d = '0;
        if (is_subu)       alu_d = a_q - b_q;
        else if (is_and)   alu_d = a_q & b_q;
        else if (is_or)    alu_d = a_q | b_q;
        else if (is_slt)   alu_d = {31'b0, ($signed(a_q) < $signed(b_q))};
        else if (is_addu)  alu_d = a_q + b_q;
        else if (is_ori)   alu_d = a_q | imm_q;
        else if (is_lui)   alu_d = {imm16, 16'h0000};
        else               alu_d = a_q + imm_q;
    end

    assign branch_taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    assign br_target_d  = pc_q + {imm_q[29:0], 2'b00};
    assign j_target_d   = {pc_q[31:28], ir_q[25:0], 2'b00};
    assign wb_idx_d     = is_ralu ? rd : rt;
    assign wb_data_d    = is_lw ? mdr_q : alu_q;
    assign mem_timeout  = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    // Gated by reset so the bus is idle during reset yet the very first
    // cycle after release already presents the fetch of RESET_PC.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (state_q == S_FETCH) begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end else if (state_q == S_MEM) begin
                mem_req  = 1'b1;
                mem_addr = alu_q;
                mem_we   = is_sw;
                if (is_sw) mem_wdata = b_q;
            end
        end
    end

    assign halt    = (state_q == S_HALT);
    assign pc_out  = pc_q;
    assign retired = retired_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            retired_q <= '0;
            wait_q    <= '0;
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_q + 32'd4;
                        wait_q  <= '0;
                        state_q <= S_DECODE;
                    end else if (mem_timeout) begin
                        state_q <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_DECODE: begin
                    a_q   <= rf_q[rs];
                    b_q   <= rf_q[rt];
                    imm_q <= is_ori ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
                    state_q <= legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    if (is_ralu || is_ialu) begin
                        alu_q   <= alu_d;
                        state_q <= S_WB;
                    end else if (is_lw || is_sw) begin
                        alu_q   <= alu_d;
                        state_q <= (alu_d[1:0] != 2'b00) ? S_HALT : S_MEM;
                    end else if (is_beq || is_bne) begin
                        if (branch_taken) pc_q <= br_target_d;
                        retired_q <= retired_q + 32'd1;
                        state_q   <= S_FETCH;
                    end else if (is_j || is_jal) begin
                        pc_q <= j_target_d;
                        if (is_jal) rf_q[31] <= pc_q;
                        retired_q <= retired_q + 32'd1;
                        state_q   <= S_FETCH;
                    end else if (is_jr && (a_q[1:0] == 2'b00)) begin
                        pc_q      <= a_q;
                        retired_q <= retired_q + 32'd1;
                        state_q   <= S_FETCH;
                    end else begin
                        state_q <= S_HALT;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_q <= '0;
                        if (is_sw) begin
                            retired_q <= retired_q + 32'd1;
                            state_q   <= S_FETCH;
                        end else begin
                            mdr_q   <= mem_rdata;
                            state_q <= S_WB;
                        end
                    end else if (mem_timeout) begin
                        state_q <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_WB: begin
                    if (wb_idx_d != 5'd0) rf_q[wb_idx_d] <= wb_data_d;
                    retired_q <= retired_q + 32'd1;
                    state_q   <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_cycle_cpu.sv
// Directed programs for m_cycle_cpu; stores are checked by a scoreboard
// monitor, timing/state by direct samples half-way through the cycle.
module tb_m_cycle_cpu;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        halt;
    logic [31:0] pc_out;
    logic [31:0] retired;

    m_cycle_cpu #(.RESET_PC(32'h0000_3000), .MEM_TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halt      (halt),
        .pc_out    (pc_out),
        .retired   (retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    logic [31:0] mem [0:4095];
    store_t      exp_q[$];
    store_t      exp_e;
    int          fetch_wait = 0;
    int          data_wait  = 0;
    bit          stall_all  = 1'b0;
    int          wcnt       = 0;
    int          lat        = 0;
    int          checks     = 0;
    int          errors     = 0;
    int          cyc        = 0;
    bit          prev_wait  = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[13:2]] = w;
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic begin_reset();
        tick(1);
        reset      = 1'b1;
        fetch_wait = 0;
        data_wait  = 0;
        stall_all  = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        tick(2);
    endtask

    task automatic release_reset();
        tick(1);
        reset = 1'b0;
        #1;
        check32("first_req", {31'b0, mem_req}, 32'd1);
        check32("first_addr", mem_addr, 32'h0000_3000);
    endtask

    task automatic wait_ret(input logic [31:0] target, input int budget, output int n);
        n = 0;
        while (retired != target && n < budget) begin
            tick(1);
            n++;
        end
        check32("reach_retired", retired, target);
    endtask

    // Memory model: decides mem_ready for the next edge once outputs settle.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (reset || !mem_req) begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end else if (stall_all) begin
                mem_ready = 1'b0;
            end else begin
                lat = (mem_addr[13:12] == 2'b11) ? fetch_wait : data_wait;
                if (wcnt >= lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[13:2]];
                    if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    // Scoreboard monitor: every completing store is popped and compared.
    initial begin
        forever begin
            @(posedge clock);
            #3;
            if (reset) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && mem_req) begin
                    check32("stable_addr", mem_addr, p_addr);
                    check32("stable_we", {31'b0, mem_we}, {31'b0, p_we});
                    check32("stable_wdata", mem_wdata, p_wdata);
                end
                if (mem_req && mem_ready && mem_we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_store addr=%h data=%h expected=none", mem_addr, mem_wdata);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check32("store_addr", mem_addr, exp_e.addr);
                        check32("store_data", mem_wdata, exp_e.data);
                    end
                end
                prev_wait = mem_req && !mem_ready;
                p_addr    = mem_addr;
                p_we      = mem_we;
                p_wdata   = mem_wdata;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ALU ops, immediates, $0, sw, branches, illegal funct
        begin_reset();
        check32("rst_pc", pc_out, 32'h0000_3000);
        check32("rst_retired", retired, 32'd0);
        check32("rst_req", {31'b0, mem_req}, 32'd0);
        check32("rst_addr", mem_addr, 32'd0);
        check32("rst_halt", {31'b0, halt}, 32'd0);
        put(32'h3000, i_op(6'h0D, 0, 1, 16'h1234));
        put(32'h3004, r_op(1, 1, 2, 6'h21));
        put(32'h3008, i_op(6'h2B, 0, 2, 16'h0004));
        put(32'h300C, i_op(6'h0F, 0, 3, 16'h8000));
        put(32'h3010, r_op(0, 1, 4, 6'h23));
        put(32'h3014, r_op(3, 1, 5, 6'h2A));
        put(32'h3018, r_op(1, 3, 6, 6'h2A));
        put(32'h301C, r_op(4, 2, 7, 6'h24));
        put(32'h3020, r_op(3, 1, 8, 6'h25));
        put(32'h3024, i_op(6'h09, 1, 9, 16'hFFFC));
        put(32'h3028, i_op(6'h0D, 0, 10, 16'h8001));
        put(32'h302C, r_op(1, 1, 0, 6'h21));
        put(32'h3030, i_op(6'h2B, 0, 4, 16'h0010));
        put(32'h3034, i_op(6'h2B, 0, 5, 16'h0014));
        put(32'h3038, i_op(6'h2B, 0, 6, 16'h0018));
        put(32'h303C, i_op(6'h2B, 0, 7, 16'h001C));
        put(32'h3040, i_op(6'h2B, 0, 8, 16'h0020));
        put(32'h3044, i_op(6'h2B, 0, 9, 16'h0024));
        put(32'h3048, i_op(6'h2B, 0, 10, 16'h0028));
        put(32'h304C, i_op(6'h2B, 0, 0, 16'h002C));
        put(32'h3050, i_op(6'h2B, 0, 3, 16'h0030));
        put(32'h3054, i_op(6'h05, 1, 0, 16'h0001));
        put(32'h3058, i_op(6'h2B, 0, 1, 16'h0040));
        put(32'h305C, i_op(6'h04, 1, 0, 16'h0005));
        put(32'h3060, i_op(6'h2B, 0, 1, 16'h0034));
        put(32'h3064, 32'h0000_003F);
        expect_store(32'h04, 32'h0000_2468);
        expect_store(32'h10, 32'hFFFF_EDCC);
        expect_store(32'h14, 32'h0000_0001);
        expect_store(32'h18, 32'h0000_0000);
        expect_store(32'h1C, 32'h0000_2448);
        expect_store(32'h20, 32'h8000_1234);
        expect_store(32'h24, 32'h0000_1230);
        expect_store(32'h28, 32'h0000_8001);
        expect_store(32'h2C, 32'h0000_0000);
        expect_store(32'h30, 32'h8000_0000);
        expect_store(32'h34, 32'h0000_1234);
        release_reset();
        tick(7);
        check32("ret_cycle7", retired, 32'd1);
        tick(1);
        check32("ret_cycle8", retired, 32'd2);
        check32("pc_cycle8", pc_out, 32'h0000_3008);
        wait_ret(32'd24, 200, cyc);
        check32("pc_before_illegal", pc_out, 32'h0000_3064);
        tick(3);
        check32("illegal_halt", {31'b0, halt}, 32'd1);
        check32("illegal_req", {31'b0, mem_req}, 32'd0);
        tick(5);
        check32("halt_ret_hold", retired, 32'd24);
        check32("halt_pc_hold", pc_out, 32'h0000_3068);
        check32("sb_empty_t1", exp_q.size(), 32'd0);

        // sw then lw, three wait cycles on each data access
        begin_reset();
        data_wait = 3;
        put(32'h3000, i_op(6'h0D, 0, 2, 16'h2468));
        put(32'h3004, i_op(6'h2B, 0, 2, 16'h0004));
        put(32'h3008, i_op(6'h23, 0, 3, 16'h0004));
        put(32'h300C, i_op(6'h2B, 0, 3, 16'h0008));
        put(32'h3010, 32'hFC00_0000);
        expect_store(32'h04, 32'h0000_2468);
        expect_store(32'h08, 32'h0000_2468);
        release_reset();
        wait_ret(32'd1, 50, cyc);
        check32("ori_cycles", cyc, 32'd4);
        wait_ret(32'd2, 50, cyc);
        check32("sw_wait_cycles", cyc, 32'd7);
        wait_ret(32'd3, 50, cyc);
        check32("lw_wait_cycles", cyc, 32'd8);
        wait_ret(32'd4, 50, cyc);
        tick(3);
        check32("t2_halt", {31'b0, halt}, 32'd1);
        check32("t2_retired", retired, 32'd4);
        check32("sb_empty_t2", exp_q.size(), 32'd0);

        // beq $0,$0,-1 spins at RESET_PC; then retired wraps
        begin_reset();
        put(32'h3000, i_op(6'h04, 0, 0, 16'hFFFF));
        release_reset();
        tick(2);
        check32("loop_ret0", retired, 32'd0);
        tick(1);
        check32("loop_ret1", retired, 32'd1);
        check32("loop_pc1", pc_out, 32'h0000_3000);
        for (int k = 2; k <= 4; k++) begin
            tick(3);
            check32("loop_ret", retired, 32'(k));
            check32("loop_pc", pc_out, 32'h0000_3000);
        end
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        tick(2);
        check32("wrap_pre", retired, 32'hFFFF_FFFF);
        tick(1);
        check32("wrap_zero", retired, 32'd0);

        // jal / jr
        begin_reset();
        put(32'h3000, i_op(6'h05, 31, 0, 16'h0003));
        put(32'h3004, j_op(6'h03, 26'h000_0C00));
        put(32'h3008, i_op(6'h2B, 0, 31, 16'h0050));
        put(32'h300C, 32'hFC00_0000);
        put(32'h3010, r_op(31, 0, 0, 6'h08));
        expect_store(32'h50, 32'h0000_3008);
        release_reset();
        wait_ret(32'd1, 20, cyc);
        check32("bne_cycles", cyc, 32'd3);
        wait_ret(32'd2, 20, cyc);
        check32("jal_cycles", cyc, 32'd3);
        check32("jal_pc", pc_out, 32'h0000_3000);
        wait_ret(32'd3, 20, cyc);
        check32("bne_taken_pc", pc_out, 32'h0000_3010);
        wait_ret(32'd4, 20, cyc);
        check32("jr_cycles", cyc, 32'd3);
        check32("jr_pc", pc_out, 32'h0000_3008);
        wait_ret(32'd5, 20, cyc);
        tick(3);
        check32("t4_halt", {31'b0, halt}, 32'd1);
        check32("t4_retired", retired, 32'd5);
        check32("sb_empty_t4", exp_q.size(), 32'd0);

        // misaligned lw halts without retiring; reset recovers
        begin_reset();
        put(32'h3000, i_op(6'h23, 0, 1, 16'h0002));
        release_reset();
        tick(4);
        check32("mis_halt", {31'b0, halt}, 32'd1);
        check32("mis_req", {31'b0, mem_req}, 32'd0);
        check32("mis_retired", retired, 32'd0);
        tick(3);
        check32("mis_pc_hold", pc_out, 32'h0000_3004);
        tick(1);
        reset = 1'b1;
        #1;
        check32("rst2_req", {31'b0, mem_req}, 32'd0);
        check32("rst2_addr", mem_addr, 32'd0);
        check32("rst2_we", {31'b0, mem_we}, 32'd0);
        check32("rst2_wdata", mem_wdata, 32'd0);
        check32("rst2_halt", {31'b0, halt}, 32'd0);
        check32("rst2_pc", pc_out, 32'h0000_3000);
        release_reset();

        // memory never ready: timeout after 16 wait cycles
        begin_reset();
        stall_all = 1'b1;
        release_reset();
        tick(15);
        check32("tmo_halt15", {31'b0, halt}, 32'd0);
        check32("tmo_req15", {31'b0, mem_req}, 32'd1);
        tick(1);
        check32("tmo_halt16", {31'b0, halt}, 32'd1);
        check32("tmo_req16", {31'b0, mem_req}, 32'd0);
        check32("tmo_retired", retired, 32'd0);

        // reset in the middle of a stalled fetch aborts it
        begin_reset();
        stall_all = 1'b1;
        release_reset();
        tick(5);
        reset = 1'b1;
        #1;
        check32("abort_req", {31'b0, mem_req}, 32'd0);
        check32("abort_addr", mem_addr, 32'd0);
        stall_all = 1'b0;
        put(32'h3000, i_op(6'h04, 0, 0, 16'hFFFF));
        release_reset();
        tick(3);
        check32("abort_ret", retired, 32'd1);
        check32("abort_pc", pc_out, 32'h0000_3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
